// File: rtl/key_step_pkg.sv
// Shared FSM encodings, default timing constants and counter sizing for the key step front end.
package key_step_pkg;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_step_gen_debounce_filter.sv
// Synchronizer plus debounce filter for a slow level input; level moves only after a
// full debounce window of stable samples of the new value.
module debounce_filter
  import key_step_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   level_q;
  logic                   pending_q;
  logic [CW-1:0]          cnt_q;

  assign sample = sync_q[SYNC_STAGES-1];
  assign level  = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // The first differing sample arms the filter, then DEBOUNCE_CYCLES more must agree,
  // which keeps this path exactly as slow as the key press path.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else if (!pending_q) begin
      if (sample != level_q) begin
        pending_q <= 1'b1;
        cnt_q     <= '0;
      end
    end else if (sample == level_q) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q   <= sample;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/key_step_gen.sv
// Pushbutton front end: one clean step pulse per debounced press plus a debounced direction.
// Optional auto-repeat while held is enabled with the macro KEY_STEP_AUTO_REPEAT_EN.
module key_step_gen
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic sw_raw,
  output logic step,
  output logic dir,
  output logic pressed
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("key_step_gen: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] key_sync_q;
  logic                   kp;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   step_q, step_d;
  logic                   pressed_q, pressed_d;
  logic                   dir_q;
  logic                   sw_level;
  logic                   rpt_fire;

  assign kp      = key_sync_q[SYNC_STAGES-1];
  assign step    = step_q;
  assign pressed = pressed_q;
  assign dir     = dir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync_q <= '0;
    end else begin
      key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], ~key_n};
    end
  end

`ifdef KEY_STEP_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = cnt_width(RMAX);
  localparam logic [RCW-1:0] RPT_FIRST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RPT_NEXT  = RCW'(REPEAT_RATE - 1);

  logic [RCW-1:0] rpt_cnt_q;
  logic           rpt_first_q;

  // Repeats only follow a real accepted press; a key held through reset lands in HELD
  // with pressed low and must stay silent.
  assign rpt_fire = (state_q == HELD) && kp && pressed_q &&
                    (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT));

  always_ff @(posedge clk) begin
    if (reset || state_q != HELD || !kp) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
    end else if (rpt_cnt_q != '1) begin
      rpt_cnt_q <= rpt_cnt_q + RCW'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = 1'b0;
    pressed_d = pressed_q;
    case (state_q)
      IDLE: begin
        if (kp) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!kp) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HELD;
          step_d    = 1'b1;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!kp) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
          step_d = rpt_fire;
        end
      end
      default: begin
        // RELEASE_WAIT: a bounce back to pressed resumes HELD without a new step.
        if (kp) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RELEASE_WAIT;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      pressed_q <= pressed_d;
    end
  end

  debounce_filter #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dir_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (sw_raw),
    .level (sw_level)
  );

  // Extra stage so a switch change resolving together with a press shows up after the step.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= sw_level;
    end
  end

endmodule

// File: doc/key_step_gen.md
Name: key_step_gen

Overview:
- Front end for the board's pushbutton-driven counters.
- Takes a raw, bouncing, active-low pushbutton and a raw slide switch.
- Emits one clean single-cycle step pulse per physical press, plus a debounced direction level.
- Sits between the board pins and the up/down counter / 7-seg path, so the counter can run on the system clock instead of clocking on a key edge.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); minimum 2.
- SYNC_STAGES, 2: flip-flop synchronizer depth on each raw input; minimum 2.
- REPEAT_DELAY, 25000000: cycles in HELD before the first auto-repeat step (AUTO_REPEAT_EN only).
- REPEAT_RATE, 5000000: cycles between subsequent auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- key_n  in  1  raw pushbutton, 0 = pressed, asynchronous.
- sw_raw  in  1  raw slide switch, asynchronous.
- step  out  1  single-cycle pulse; one per accepted press (plus repeats if enabled).
- dir  out  1  debounced switch level; 1 = up, 0 = down.
- pressed  out  1  debounced key level; 1 while key is accepted as held.

Behaviour:
- Reset values: step=0, dir=0, pressed=0, synchronizers cleared to "released"/0, all counters 0, FSM in RELEASE_WAIT.
- key_n is inverted, then passed through SYNC_STAGES flops; the FSM sees only the synchronized level kp.
- FSM states:
  - IDLE: kp=1 -> PRESS_WAIT with the debounce counter cleared.
  - PRESS_WAIT: counts cycles with kp=1. Any kp=0 -> IDLE, no step. When the counter reaches DEBOUNCE_CYCLES-1 with kp=1 -> HELD; step=1 for exactly that one cycle; pressed goes 1 in the same cycle.
  - HELD: kp=0 -> RELEASE_WAIT with the counter cleared.
  - RELEASE_WAIT: counts cycles with kp=0. Any kp=1 -> HELD with no new step, and pressed stays 1. Counter reaches DEBOUNCE_CYCLES-1 with kp=0 -> IDLE; pressed=0.
- Reset-to-RELEASE_WAIT rule: a key held through reset release produces no step until it has been released for DEBOUNCE_CYCLES cycles and then pressed again.
- Latency: key_n is stable low from edge E. step is high in cycle E + SYNC_STAGES + DEBOUNCE_CYCLES, counting E's own synchronizer capture as cycle E+1.
- dir path:
  - sw_raw goes through its own synchronizer and debounce filter with the same DEBOUNCE_CYCLES.
  - dir changes only after DEBOUNCE_CYCLES stable samples of the new value.
  - A glitch shorter than that leaves dir unchanged.
- Simultaneous dir change and step: the dir value in the step cycle is the pre-change value; the new value appears no earlier than the next cycle. Consumers sample dir together with step.
- Counter widths: $clog2 of the parameter. Counters saturate and never wrap.
- Reset asserted mid-operation: cycle-accurate return to reset values on the next edge; no partial step pulse.
- At most one step per cycle; no two steps closer than DEBOUNCE_CYCLES apart without AUTO_REPEAT_EN.

Optional Feature:
- Macro: KEY_STEP_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs from entry.
  - The first extra step comes REPEAT_DELAY cycles after the press step.
  - Further steps come every REPEAT_RATE cycles while in HELD.
  - The counter clears on leaving HELD. A RELEASE_WAIT bounce back into HELD restarts the counter from 0.
- Undefined: no repeat counter is synthesized; exactly one step per press. REPEAT_DELAY and REPEAT_RATE are ignored.

Decomposition:
- Package key_step_pkg:
  - FSM state enum: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - Default timing constants.
  - A function returning counter width for a cycle count.
- Sub-module debounce_filter (parameters SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, reset, raw, level). Used for the sw_raw path. The key path keeps its own FSM because it needs the step event and the release-before-press behaviour after reset.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=20, REPEAT_RATE=8):
- Clean press: key_n low at edge 10 and held -> step=1 only at cycle 16; pressed=1 from 16; release at 40 -> pressed=0 at 46; no further step.
- Bounce: key_n low 2 cycles, high 1, low 2, high, repeated for 30 cycles -> step never asserts; pressed stays 0.
- Release bounce: held press, then key_n high 2 cycles, low again -> no second step; pressed stays 1.
- Reset while held: key_n low throughout; reset 1 for cycles 0-3 -> no step; after release (>=4 stable cycles) and re-press -> exactly one step.
- Direction: sw_raw 0->1 at cycle 5, press lands at the same cycle dir updates -> step cycle shows dir=0, next cycle dir=1; a 3-cycle sw_raw glitch leaves dir unchanged.
- Auto-repeat (macro defined): hold 60 cycles after press step at cycle T -> steps at T, T+20, T+28, T+36, T+44, ...; macro undefined -> only T.
